riscv_fetch_unit: RTL and testbench

Instruction-fetch stage of the RV32I pipeline. It owns the program counter, issues instruction-memory requests over a request/grant + response-valid interface, and buffers fetched words in order. It presents {PC, PC+4, instruction} to the IF/ID pipeline register. Redirects from execute and stalls from the hazard unit are handled here so that IF/ID only ever sees in-order, non-stale instructions.

---
 rtl/riscv_fetch_unit_pkg.sv | 19 +
 rtl/riscv_fetch_queue.sv | 110 +++++++++++
 rtl/riscv_fetch_unit.sv | 122 ++++++++++++
 tb/tb_riscv_fetch_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// riscv_fetch_unit_pkg
// Shared constants for the RV32I instruction-fetch stage: data width, the
// canonical NOP encoding, default reset PC / queue depth, and a PC alignment
// helper.
// ---------------------------------------------------------------------------
package riscv_fetch_unit_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RV_NOP       = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          FQ_DEPTH_DEF = 3;

    // Instruction fetches are always word aligned; low two bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/riscv_fetch_queue.sv
// ---------------------------------------------------------------------------
// riscv_fetch_queue
// In-order circular buffer of DEPTH {pc, inst, ready} entries.
// An entry is allocated when its memory request is granted and is marked
// ready when its response returns. Responses return in request order, so
// the not-ready entries always form a contiguous run ending at the tail and
// the oldest not-ready entry is tracked with its own pointer (fill_q).
//
// Ports:
//   i_clk, i_rstn         clock, asynchronous active-low reset
//   alloc_i, alloc_pc_i   allocate tail entry with this PC (ignored if full)
//   fill_i, fill_data_i   write data into oldest not-ready entry, mark ready
//   pop_i                 drop head entry (ignored unless head is ready)
//   flush_i               invalidate every entry; overrides alloc/fill/pop
//   head_valid_o          head entry exists and holds returned data
//   head_pc_o             PC of head entry
//   head_inst_o           head instruction, NOP when head is not valid
//   count_o               number of allocated entries
//   nrdy_o                number of allocated entries still awaiting data
// ---------------------------------------------------------------------------
module riscv_fetch_queue
    import riscv_fetch_unit_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH_DEF
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    input  logic                        alloc_i,
    input  logic [XLEN-1:0]             alloc_pc_i,
    input  logic                        fill_i,
    input  logic [XLEN-1:0]             fill_data_i,
    input  logic                        pop_i,
    input  logic                        flush_i,
    output logic                        head_valid_o,
    output logic [XLEN-1:0]             head_pc_o,
    output logic [XLEN-1:0]             head_inst_o,
    output logic [$clog2(DEPTH+1)-1:0]  count_o,
    output logic [$clog2(DEPTH+1)-1:0]  nrdy_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [XLEN-1:0] inst_q [DEPTH];
    logic            rdy_q  [DEPTH];
    logic [PW-1:0]   head_q, tail_q, fill_q;
    logic [CW-1:0]   count_q, nrdy_q;

    logic alloc_en, fill_en, pop_en;

    // Pointer increment with wrap; DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign head_valid_o = (count_q != '0) && rdy_q[head_q];
    assign head_pc_o    = pc_q[head_q];
    assign head_inst_o  = head_valid_o ? inst_q[head_q] : RV_NOP;
    assign count_o      = count_q;
    assign nrdy_o       = nrdy_q;

    // Guards keep the buffer consistent even if a caller misbehaves.
    assign alloc_en = alloc_i && (count_q != CW'(DEPTH));
    assign fill_en  = fill_i && (nrdy_q != '0);
    assign pop_en   = pop_i && head_valid_o;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
            nrdy_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= RV_NOP;
                rdy_q[i]  <= 1'b0;
            end
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
            nrdy_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rdy_q[i] <= 1'b0;
            end
        end else begin
            // tail, fill and head never alias when their enables are set:
            // alloc needs a free slot, fill targets a not-ready entry, pop a ready one.
            if (alloc_en) begin
                pc_q[tail_q]  <= alloc_pc_i;
                rdy_q[tail_q] <= 1'b0;
                tail_q        <= ptr_inc(tail_q);
            end
            if (fill_en) begin
                inst_q[fill_q] <= fill_data_i;
                rdy_q[fill_q]  <= 1'b1;
                fill_q         <= ptr_inc(fill_q);
            end
            if (pop_en) begin
                head_q <= ptr_inc(head_q);
            end
            count_q <= count_q + CW'(alloc_en) - CW'(pop_en);
            nrdy_q  <= nrdy_q + CW'(alloc_en) - CW'(fill_en);
        end
    end

endmodule

// File: rtl/riscv_fetch_unit.sv
// ---------------------------------------------------------------------------
// riscv_fetch_unit
// RV32I instruction-fetch stage. Owns the PC, issues in-order instruction
// memory requests, buffers responses in riscv_fetch_queue and presents the
// oldest returned instruction to IF/ID. Redirects flush the queue; responses
// for requests already in flight at a redirect are counted in kill_q and
// dropped when they return.
//
// Memory handshake: a request transfers in any cycle where o_imem_req and
// i_imem_gnt are both high; o_imem_req/o_imem_addr depend only on registered
// state. Each transferred request produces exactly one i_imem_rvalid pulse
// in a later cycle, in request order.
//
// Ports:
//   i_clk, i_rstn               clock, asynchronous active-low reset
//   o_imem_req, o_imem_addr     fetch request and word-aligned address
//   i_imem_gnt                  request accepted this cycle
//   i_imem_rvalid, i_imem_rdata response valid and instruction word
//   i_stall                     IF/ID holding; head not consumed
//   i_redirect, i_redirect_pc   flush and restart fetch at new PC
//   o_if_valid                  head instruction valid
//   o_if_pc, o_if_pc4           head PC and head PC + 4
//   o_if_inst                   head instruction (NOP when not valid)
// ---------------------------------------------------------------------------
module riscv_fetch_unit
    import riscv_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          FQ_DEPTH = FQ_DEPTH_DEF
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    input  logic            i_stall,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_if_valid,
    output logic [XLEN-1:0] o_if_pc,
    output logic [XLEN-1:0] o_if_pc4,
    output logic [XLEN-1:0] o_if_inst
);

    localparam int CW = $clog2(FQ_DEPTH + 1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   kill_q, kill_d, kill_sum;
    logic            run_q;          // low during the reset-release cycle
    logic [CW-1:0]   fq_count, fq_nrdy;
    logic [CW:0]     inflight;
    logic            fire, alloc, fill, pop, head_valid;
    logic [XLEN-1:0] head_pc;

    // Allocated entries plus responses still to be discarded may never
    // exceed the queue depth, which also bounds kill_q.
    assign inflight    = {1'b0, fq_count} + {1'b0, kill_q};
    assign o_imem_req  = run_q && (inflight < (CW+1)'(FQ_DEPTH));
    assign o_imem_addr = pc_q;

    assign fire  = o_imem_req && i_imem_gnt;
    assign alloc = fire && !i_redirect;
    assign fill  = i_imem_rvalid && (kill_q == '0) && !i_redirect;
    assign pop   = head_valid && !i_stall && !i_redirect;

    // On redirect every not-yet-returned request, including one granted in
    // this very cycle, becomes stale; a response arriving now retires one.
    assign kill_sum = kill_q + fq_nrdy + CW'(fire);

    always_comb begin
        pc_d   = pc_q;
        kill_d = kill_q;
        if (i_redirect) begin
            pc_d   = word_align(i_redirect_pc);
            kill_d = (i_imem_rvalid && (kill_sum != '0)) ? kill_sum - CW'(1) : kill_sum;
        end else begin
            if (fire) begin
                pc_d = pc_q + XLEN'(4);
            end
            if (i_imem_rvalid && (kill_q != '0)) begin
                kill_d = kill_q - CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pc_q   <= RESET_PC;
            kill_q <= '0;
            run_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            kill_q <= kill_d;
            run_q  <= 1'b1;
        end
    end

    riscv_fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .alloc_i      (alloc),
        .alloc_pc_i   (pc_q),
        .fill_i       (fill),
        .fill_data_i  (i_imem_rdata),
        .pop_i        (pop),
        .flush_i      (i_redirect),
        .head_valid_o (head_valid),
        .head_pc_o    (head_pc),
        .head_inst_o  (o_if_inst),
        .count_o      (fq_count),
        .nrdy_o       (fq_nrdy)
    );

    assign o_if_valid = head_valid;
    assign o_if_pc    = head_pc;
    assign o_if_pc4   = head_pc + XLEN'(4);

endmodule

// File: tb/tb_riscv_fetch_unit.sv
module tb_riscv_fetch_unit;
    import riscv_fetch_unit_pkg::*;

    localparam int DEPTH = 3;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = '0;
    logic        i_stall = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_if_valid;
    logic [31:0] o_if_pc;
    logic [31:0] o_if_pc4;
    logic [31:0] o_if_inst;

    riscv_fetch_unit dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_if_valid    (o_if_valid),
        .o_if_pc       (o_if_pc),
        .o_if_pc4      (o_if_pc4),
        .o_if_inst     (o_if_inst)
    );

    // ---------------- clock ----------------
    always #5 i_clk = ~i_clk;

    // ---------------- reference model state ----------------
    // Memory: in-order list of outstanding requests with due cycle and a
    // flag saying whether the fetch stage should discard the response.
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    mreq_t       memq[$];
    logic [31:0] live_q[$];   // PCs of current-stream fetches not yet consumed
    int          live_ret;    // how many of live_q (from the front) have data
    logic [31:0] next_pc;     // next PC the stage should request
    bit          started;
    int          cyc;
    int          lat;
    int          gnt_pct;
    int          total;
    int          bad;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int hold);
        i_rstn        = 1'b0;
        i_imem_gnt    = 1'b0;
        i_imem_rvalid = 1'b0;
        i_stall       = 1'b0;
        i_redirect    = 1'b0;
        #1;
        check("rst_req",   o_imem_req, 0);
        check("rst_valid", o_if_valid, 0);
        check("rst_pc",    o_if_pc,    32'h0);
        check("rst_pc4",   o_if_pc4,   32'h4);
        check("rst_inst",  o_if_inst,  RV_NOP);
        memq.delete();
        live_q.delete();
        live_ret = 0;
        next_pc  = 32'h0;
        started  = 1'b0;
        repeat (hold) @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
    endtask

    // One clock cycle: drive memory, check outputs against the model,
    // advance the clock, then update the model with what happened.
    task automatic cycle();
        bit    rv;
        bit    fire;
        bit    pop;
        bit    exp_req;
        bit    exp_valid;
        int    stale_n;
        mreq_t m;

        i_imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
        rv            = (memq.size() > 0) && (memq[0].due <= cyc);
        i_imem_rvalid = rv;
        i_imem_rdata  = rv ? mem_word(memq[0].addr) : $urandom;

        stale_n = 0;
        foreach (memq[i]) if (memq[i].stale) stale_n++;
        exp_req   = started && ((live_q.size() + stale_n) < DEPTH);
        exp_valid = (live_ret > 0);

        check("req", o_imem_req, exp_req);
        if (exp_req) check("addr", o_imem_addr, next_pc);
        check("valid", o_if_valid, exp_valid);
        if (exp_valid) begin
            check("if_pc",   o_if_pc,   live_q[0]);
            check("if_pc4",  o_if_pc4,  live_q[0] + 32'd4);
            check("if_inst", o_if_inst, mem_word(live_q[0]));
        end else begin
            check("if_nop", o_if_inst, RV_NOP);
        end

        fire = exp_req && i_imem_gnt;
        pop  = exp_valid && !i_stall && !i_redirect;

        @(posedge i_clk);
        #1;
        cyc++;
        started = 1'b1;

        if (rv) begin
            m = memq.pop_front();
            if (!m.stale) live_ret++;
        end
        if (pop) begin
            void'(live_q.pop_front());
            live_ret--;
        end
        if (fire) begin
            m.addr  = next_pc;
            m.due   = cyc - 1 + lat;
            m.stale = i_redirect;
            memq.push_back(m);
            if (!i_redirect) live_q.push_back(next_pc);
        end
        if (i_redirect) begin
            foreach (memq[i]) memq[i].stale = 1'b1;
            live_q.delete();
            live_ret = 0;
            next_pc  = i_redirect_pc & ~32'h3;
        end else if (fire) begin
            next_pc = next_pc + 32'd4;
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        total   = 0;
        bad     = 0;
        cyc     = 0;
        lat     = 1;
        gnt_pct = 100;

        // Zero-wait memory stream from reset.
        do_reset(3);
        repeat (20) cycle();

        // Three-cycle memory latency: queue fills, req throttles.
        lat = 3;
        repeat (20) cycle();

        // Stall for five cycles while streaming.
        i_stall = 1'b1;
        repeat (5) cycle();
        i_stall = 1'b0;
        repeat (10) cycle();

        // Redirect to 0x100 with requests outstanding.
        i_redirect_pc = 32'h0000_0100;
        i_redirect    = 1'b1;
        cycle();
        i_redirect    = 1'b0;
        repeat (15) cycle();

        // Unaligned redirect in the same cycle as rvalid and gnt.
        lat = 1;
        repeat (10) cycle();
        i_redirect_pc = 32'h0000_0102;
        i_redirect    = 1'b1;
        cycle();
        i_redirect    = 1'b0;
        repeat (10) cycle();

        // PC wrap at the top of the address space.
        i_redirect_pc = 32'hFFFF_FFF8;
        i_redirect    = 1'b1;
        cycle();
        i_redirect    = 1'b0;
        repeat (10) cycle();

        // Asynchronous reset mid-stream.
        do_reset(2);
        repeat (10) cycle();

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            if ((n % 40) == 0) begin
                gnt_pct = $urandom_range(30, 100);
                lat     = $urandom_range(1, 4);
            end
            i_stall       = ($urandom_range(0, 3) == 0);
            i_redirect    = ($urandom_range(0, 19) == 0);
            i_redirect_pc = $urandom;
            cycle();
        end
        i_stall    = 1'b0;
        i_redirect = 1'b0;
        gnt_pct    = 100;
        repeat (10) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
